// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I ALU opcode and operand-select constants
package rv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    localparam logic ALUSRC_REG = 1'b0;
    localparam logic ALUSRC_IMM = 1'b1;

endpackage

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - combinational 32-bit ALU with opcode decode and zero detect
module rv_alu
    import rv_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    input  logic        mul_en_i,
    input  logic [31:0] mul_res_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Opcode decode; anything unrecognised (or MUL when not built in) yields zero.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {31'd0, (a_i < b_i)};
            ALU_MUL:  result_o = mul_en_i ? mul_res_i : '0;
            default:  result_o = '0;
        endcase
    end

    // Zero flag follows the final decoded result, so illegal opcodes report zero.
    always_comb begin
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - RV32I execute stage; STAGE_EX_MUL_EN builds in the MUL opcode
module stage_ex
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] reg_data1,
    input  logic [31:0] reg_data2,
    input  logic [31:0] imm,
    input  logic        alusrc,
    input  logic [3:0]  aluop,
    output logic [31:0] aluout,
    output logic        zero,
    output logic [31:0] aluout_q,
    output logic        zero_q
);

    logic [31:0] op_b;
    logic [31:0] mul_res;
    logic        mul_en;
    logic [31:0] aluout_d;
    logic        zero_d;

    // Operand B select between register and immediate.
    always_comb begin
        op_b = (alusrc == ALUSRC_IMM) ? imm : reg_data2;
    end

`ifdef STAGE_EX_MUL_EN
    assign mul_en  = 1'b1;
    assign mul_res = reg_data1 * op_b;
`else
    assign mul_en  = 1'b0;
    assign mul_res = '0;
`endif

    rv_alu u_alu (
        .a_i       (reg_data1),
        .b_i       (op_b),
        .op_i      (aluop),
        .mul_en_i  (mul_en),
        .mul_res_i (mul_res),
        .result_o  (aluout),
        .zero_o    (zero)
    );

    assign aluout_d = aluout;
    assign zero_d   = zero;

    // Trace copy of the result, captured every cycle and cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - scoreboard bench for stage_ex
module tb_stage_ex;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] imm;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] aluout;
    logic        zero;
    logic [31:0] aluout_q;
    logic        zero_q;

    typedef struct {
        logic [31:0] res;
        logic        z;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev;
    bit   have_prev;
    int   total;
    int   bad;

    stage_ex dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_data1 (reg_data1),
        .reg_data2 (reg_data2),
        .imm       (imm),
        .alusrc    (alusrc),
        .aluop     (aluop),
        .aluout    (aluout),
        .zero      (zero),
        .aluout_q  (aluout_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] im, input logic src, input logic [3:0] op,
                         input logic [31:0] exp_res, input logic exp_z);
        exp_t e;
        @(posedge clk);
        #1;
        reg_data1 = a;
        reg_data2 = r2;
        imm       = im;
        alusrc    = src;
        aluop     = op;
        e.res  = exp_res;
        e.z    = exp_z;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: combinational result checked mid-cycle, registered copy one cycle later.
    always @(negedge clk) begin
        exp_t cur;
        if (have_prev) begin
            check({prev.name, "_q"}, aluout_q, prev.res);
            check({prev.name, "_zq"}, {31'd0, zero_q}, {31'd0, prev.z});
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check(cur.name, aluout, cur.res);
            check({cur.name, "_z"}, {31'd0, zero}, {31'd0, cur.z});
            prev      = cur;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        have_prev = 1'b0;
        rst_n     = 1'b0;
        reg_data1 = '0;
        reg_data2 = '0;
        imm       = '0;
        alusrc    = 1'b0;
        aluop     = 4'b0000;
        #3;
        check("rst_aluout_q", aluout_q, 32'd0);
        check("rst_zero_q", {31'd0, zero_q}, 32'd0);
        check("rst_zero_comb", {31'd0, zero}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply("add_reg",    32'd10, 32'd5, 32'd3, 1'b0, 4'b0000, 32'd15, 1'b0);
        apply("add_imm",    32'd10, 32'd5, 32'd3, 1'b1, 4'b0000, 32'd13, 1'b0);
        apply("sub_imm",    32'd10, 32'd5, 32'd3, 1'b1, 4'b0001, 32'd7, 1'b0);
        apply("sub_zero",   32'd5, 32'd9, 32'd5, 1'b1, 4'b0001, 32'd0, 1'b1);
        apply("sub_neg",    32'd3, 32'd5, 32'd0, 1'b0, 4'b0001, 32'hFFFF_FFFE, 1'b0);
        apply("add_wrap",   32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0000, 32'd0, 1'b1);
        apply("sra",        32'h8000_0000, 32'h21, 32'd0, 1'b0, 4'b0111, 32'hC000_0000, 1'b0);
        apply("srl",        32'h8000_0000, 32'h21, 32'd0, 1'b0, 4'b0110, 32'h4000_0000, 1'b0);
        apply("sll",        32'd1, 32'd0, 32'h24, 1'b1, 4'b0101, 32'h10, 1'b0);
        apply("slt",        32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b1000, 32'd1, 1'b0);
        apply("sltu",       32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b1001, 32'd0, 1'b1);
        apply("and",        32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 4'b0010, 32'h0000_F000, 1'b0);
        apply("or",         32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 4'b0011, 32'h0000_FFF0, 1'b0);
        apply("xor",        32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 4'b0100, 32'h0000_0FF0, 1'b0);
        apply("illegal_b",  32'd6, 32'd7, 32'd0, 1'b0, 4'b1011, 32'd0, 1'b1);
`ifdef STAGE_EX_MUL_EN
        apply("mul",        32'd6, 32'd7, 32'd0, 1'b0, 4'b1010, 32'd42, 1'b0);
        apply("mul_imm",    32'd6, 32'd7, 32'd5, 1'b1, 4'b1010, 32'd30, 1'b0);
`else
        apply("mul_off",    32'd6, 32'd7, 32'd0, 1'b0, 4'b1010, 32'd0, 1'b1);
        apply("mul_off_imm", 32'd6, 32'd7, 32'd5, 1'b1, 4'b1010, 32'd0, 1'b1);
`endif
        apply("illegal_f",  32'd6, 32'd7, 32'd0, 1'b0, 4'b1111, 32'd0, 1'b1);

        // Drain the scoreboard so the monitor is idle for the reset sequence.
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        #1;
        reg_data1 = 32'd10;
        reg_data2 = 32'd5;
        imm       = 32'd3;
        alusrc    = 1'b0;
        aluop     = 4'b0000;
        @(posedge clk);
        #1;
        check("pre_rst_q", aluout_q, 32'd15);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", aluout_q, 32'd0);
        check("mid_rst_zq", {31'd0, zero_q}, 32'd0);
        check("mid_rst_comb", aluout, 32'd15);
        alusrc = 1'b1;
        aluop  = 4'b0001;
        #1;
        check("rst_track_comb", aluout, 32'd7);
        @(posedge clk);
        #1;
        check("rst_hold_q", aluout_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_q", aluout_q, 32'd7);
        check("post_rst_zq", {31'd0, zero_q}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
